// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer: FSM states, vector count,
// counter widths and the default 2-input AND truth table.
package gate_test_pkg;

    localparam int unsigned VEC_NUM = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned CNT_W   = 4;

    // Bit k is the expected gate output for input vector k = {a,b}
    localparam logic [VEC_NUM-1:0] TRUTH_AND = 4'b1000;

    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(VEC_NUM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gate_test_seq_settle_timer.sv
// Settle timer: loaded when a vector starts driving, signals expiry once the
// gate inputs have been held for SETTLE cycles.
module settle_timer
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired_c
);

    // First DRIVE cycle sees SETTLE-1, last one sees 0
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Down-counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/gate_test_seq.sv
// Gate test sequencer: sweeps all four input vectors into a 2-input gate,
// compares the gate output with TRUTH and reports the mismatch count.
// Optional macro GATE_TEST_SEQ_FAILVEC_EN enables capture of the first
// failing vector index on fail_vec; otherwise fail_vec is tied to zero.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter logic [VEC_NUM-1:0] TRUTH  = TRUTH_AND,
    parameter int unsigned        SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gate_y,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [IDX_W-1:0] fail_vec
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q, pass_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timer_load_c;
    logic             timer_exp_c;
    logic             sweep_start_c;
    logic             mismatch_c;

`ifdef GATE_TEST_SEQ_FAILVEC_EN
    logic [IDX_W-1:0] fail_vec_q, fail_vec_d;
`endif

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load_c),
        .run       (state_q == ST_DRIVE),
        .expired_c (timer_exp_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            gate_a_q  <= 1'b0;
            gate_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            gate_a_q  <= gate_a_d;
            gate_b_q  <= gate_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef GATE_TEST_SEQ_FAILVEC_EN
    // First-failing-vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_vec_q <= '0;
        end else begin
            fail_vec_q <= fail_vec_d;
        end
    end
`endif

    // Next-state logic; a new DRIVE phase reloads the settle timer
    always_comb begin
        state_d      = state_q;
        timer_load_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    timer_load_c = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (timer_exp_c) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d      = ST_DRIVE;
                    timer_load_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values, registered so they line up with state_q
    always_comb begin
        idx_d         = idx_q;
        err_cnt_d     = err_cnt_q;
        pass_d        = pass_q;
        sweep_start_c = (state_q == ST_IDLE) && (state_d == ST_DRIVE);
        mismatch_c    = (state_q == ST_CHECK) && (gate_y != TRUTH[idx_q]);

        if (sweep_start_c) begin
            idx_d     = '0;
            err_cnt_d = '0;
            pass_d    = 1'b0;
        end
        if (mismatch_c && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if ((state_q == ST_CHECK) && (state_d == ST_DRIVE)) begin
            idx_d = idx_q + IDX_W'(1);
        end
        // Verdict includes a mismatch found in the final CHECK
        if (state_d == ST_DONE) begin
            pass_d = (err_cnt_d == '0);
        end

        busy_d   = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
        gate_a_d = busy_d & idx_d[1];
        gate_b_d = busy_d & idx_d[0];
        done_d   = (state_d == ST_DONE);

`ifdef GATE_TEST_SEQ_FAILVEC_EN
        fail_vec_d = fail_vec_q;
        if (sweep_start_c) begin
            fail_vec_d = '0;
        end
        if (mismatch_c && (err_cnt_q == '0)) begin
            fail_vec_d = idx_q;
        end
`endif
    end

    assign gate_a  = gate_a_q;
    assign gate_b  = gate_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;

`ifdef GATE_TEST_SEQ_FAILVEC_EN
    assign fail_vec = fail_vec_q;
`else
    assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: an AND instance (SETTLE=2) and an OR instance
// (SETTLE=1), each driving a behavioural gate model, checked cycle by cycle
// against timing and verdicts derived from the sweep rules.
module tb_gate_test_seq;

    localparam logic [3:0] T0 = 4'b1000;
    localparam logic [3:0] T1 = 4'b1110;
    localparam int         S0 = 2;
    localparam int         S1 = 1;

`ifdef GATE_TEST_SEQ_FAILVEC_EN
    localparam bit FV_EN = 1'b1;
`else
    localparam bit FV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       start [2];
    logic       rst   [2];
    logic       ga    [2];
    logic       gb    [2];
    logic       gy    [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [2:0] err   [2];
    logic [1:0] fv    [2];
    int         mode_v [2];
    logic [3:0] flip_v [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Gate behaviour: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ideal with flipped vectors
    function automatic logic model_y(input int mode, input logic [3:0] truth,
                                     input logic [3:0] flip, input logic [1:0] k);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return truth[k] ^ flip[k];
            default: return truth[k];
        endcase
    endfunction

    assign gy[0] = model_y(mode_v[0], T0, flip_v[0], {ga[0], gb[0]});
    assign gy[1] = model_y(mode_v[1], T1, flip_v[1], {ga[1], gb[1]});

    gate_test_seq #(.TRUTH(T0), .SETTLE(S0)) dut_and (
        .clk(clk), .rst(rst[0]), .start(start[0]), .gate_y(gy[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_cnt(err[0]), .fail_vec(fv[0])
    );

    gate_test_seq #(.TRUTH(T1), .SETTLE(S1)) dut_or (
        .clk(clk), .rst(rst[1]), .start(start[1]), .gate_y(gy[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_cnt(err[1]), .fail_vec(fv[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 0);
        chk($sformatf("%s d%0d done", tag, d), 32'(done[d]), 0);
        chk($sformatf("%s d%0d gate_a", tag, d), 32'(ga[d]), 0);
        chk($sformatf("%s d%0d gate_b", tag, d), 32'(gb[d]), 0);
        chk($sformatf("%s d%0d pass", tag, d), 32'(pass[d]), 0);
        chk($sformatf("%s d%0d err_cnt", tag, d), 32'(err[d]), 0);
        chk($sformatf("%s d%0d fail_vec", tag, d), 32'(fv[d]), 0);
    endtask

    // One sweep from a start pulse at cycle 0; rp_a/rp_b re-pulse start,
    // rst_at asserts reset for one cycle (-1 disables each)
    task automatic sweep(input int d, input int mode, input logic [3:0] flip,
                         input int rp_a, input int rp_b, input int rst_at);
        logic [3:0] truth;
        bit         mism [4];
        int         s, dc, k, exp_err, exp_fv;
        bit         found, busy_e;
        string      t;
        truth = (d == 1) ? T1 : T0;
        s     = (d == 1) ? S1 : S0;
        dc    = 4 * (s + 1) + 1;
        mode_v[d] = mode;
        flip_v[d] = flip;
        for (int j = 0; j < 4; j++) begin
            mism[j] = (model_y(mode, truth, flip, 2'(j)) != truth[j]);
        end
        @(negedge clk);
        start[d] = 1'b1;
        for (int c = 1; c <= dc + 3; c++) begin
            @(negedge clk);
            start[d] = (c == rp_a) || (c == rp_b);
            rst[d]   = (c == rst_at);
            t = $sformatf("m%0d f%0h c%0d", mode, flip, c);
            if (rst_at > 0 && c > rst_at) begin
                chk_zero(d, {t, " after_rst"});
            end else begin
                exp_err = 0;
                exp_fv  = 0;
                found   = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (mism[j] && ((j + 1) * (s + 1) < c)) begin
                        exp_err++;
                        if (!found) begin
                            found  = 1'b1;
                            exp_fv = j;
                        end
                    end
                end
                busy_e = (c < dc);
                k      = (c - 1) / (s + 1);
                chk($sformatf("%s d%0d busy", t, d), 32'(busy[d]), 32'(busy_e));
                chk($sformatf("%s d%0d done", t, d), 32'(done[d]), 32'(c == dc));
                chk($sformatf("%s d%0d gate_a", t, d), 32'(ga[d]), busy_e ? ((k >> 1) & 1) : 0);
                chk($sformatf("%s d%0d gate_b", t, d), 32'(gb[d]), busy_e ? (k & 1) : 0);
                chk($sformatf("%s d%0d err_cnt", t, d), 32'(err[d]), exp_err);
                chk($sformatf("%s d%0d pass", t, d), 32'(pass[d]), 32'((c >= dc) && (exp_err == 0)));
                chk($sformatf("%s d%0d fail_vec", t, d), 32'(fv[d]), FV_EN ? exp_fv : 0);
            end
        end
        start[d] = 1'b0;
        rst[d]   = 1'b0;
    endtask

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        rst[0]   = 1'b1; rst[1]   = 1'b1;
        mode_v[0] = 0;   mode_v[1] = 0;
        flip_v[0] = '0;  flip_v[1] = '0;
        repeat (3) @(negedge clk);
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        sweep(0, 0, 4'h0, -1, -1, -1);   // ideal AND, done at 13, pass
        sweep(0, 1, 4'h0, -1, -1, -1);   // stuck-at-0: one error on vector 3
        sweep(0, 2, 4'h0, -1, -1, -1);   // stuck-at-1: three errors from vector 0
        sweep(0, 0, 4'h0,  5, 13, -1);   // start re-pulses ignored
        sweep(0, 0, 4'h0, -1, -1,  6);   // reset aborts mid-sweep
        sweep(0, 0, 4'h0, -1, -1, -1);   // clean sweep after abort
        sweep(1, 0, 4'h0, -1, -1, -1);   // ideal OR, done at 9, pass
        sweep(1, 1, 4'h0, -1, -1, -1);
        sweep(1, 2, 4'h0, -1, -1, -1);
        sweep(0, 3, 4'hF, -1, -1, -1);   // all four vectors wrong: count saturates at 4

        for (int r = 0; r < 8; r++) begin
            sweep(int'($urandom_range(0, 1)), 3, 4'($urandom), -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b1000, expected gate output per vector index (bit k = expected y for vector k; default = 2-input AND).
REQ-002 SHALL have parameter SETTLE, default 2, drive cycles per vector before sampling (legal range 1..15).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request one sweep; accepted only in IDLE.
REQ-007 SHALL have port gate_y, input, 1, output of the gate under control.
REQ-008 SHALL have ports gate_a and gate_b, output, 1 each, gate input drives.
REQ-009 SHALL have port busy, output, 1, high in DRIVE and CHECK.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at sweep end.
REQ-011 SHALL have port pass, output, 1, high when the last sweep had zero mismatches.
REQ-012 SHALL have port err_cnt, output, 3, mismatch count of the last sweep (0..4).
REQ-013 SHALL have port fail_vec, output, 2, index of the first mismatching vector.

Function
REQ-014 SHALL implement FSM IDLE -> DRIVE -> CHECK -> (DRIVE for next vector | DONE) -> IDLE.
REQ-015 SHALL transition IDLE -> DRIVE on start=1; at the same time set vector index idx=0, clear err_cnt, pass and fail_vec.
REQ-016 SHALL drive gate_a=idx[1] and gate_b=idx[0] throughout DRIVE and CHECK; both 0 in IDLE and DONE.
REQ-017 SHALL remain in DRIVE for exactly SETTLE cycles, then go to CHECK for exactly 1 cycle.
REQ-018 SHALL, in CHECK, compare gate_y with TRUTH[idx]; on mismatch increment err_cnt and, if this is the first mismatch, load fail_vec=idx.
REQ-019 SHALL, on leaving CHECK, increment idx and return to DRIVE; if idx=3, go to DONE instead.
REQ-020 SHALL, in DONE, assert done for 1 cycle, set pass=(err_cnt==0) including any mismatch found in the final CHECK, then return to IDLE.
REQ-021 SHALL place the CHECK of vector k at cycle (k+1)*(SETTLE+1) after the start cycle (cycle 0), and assert done at cycle 4*(SETTLE+1)+1.
REQ-022 SHALL ignore start outside IDLE, including start in the DONE cycle.
REQ-023 SHALL hold pass, err_cnt and fail_vec stable from DONE until the next accepted start.
REQ-024 SHALL never wrap err_cnt; its maximum is 4.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and clear idx, the settle counter, gate_a, gate_b, busy, done, pass, err_cnt and fail_vec.
REQ-026 SHALL, when reset is asserted mid-sweep, abort the sweep with no done pulse; rst takes priority over a simultaneous start.

Configuration
REQ-027 SHALL gate the fail_vec capture logic with macro GATE_TEST_SEQ_FAILVEC_EN.
REQ-028 SHALL, with the macro defined, implement fail_vec per REQ-018.
REQ-029 SHALL, without the macro, tie fail_vec to 0 with no capture register; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the FSM state enumeration, VEC_NUM=4 and the default AND truth constant in shared package gate_test_pkg.
REQ-031 SHALL implement the settle counter as sub-module settle_timer: load on DRIVE entry, assert expiry after SETTLE cycles.

Verification
REQ-032 SHALL cover: ideal AND model on gate_y, SETTLE=2, start pulse at cycle 0 -> done at cycle 13, pass=1, err_cnt=0.
REQ-033 SHALL cover: gate_y stuck at 0 -> err_cnt=1, fail_vec=3, pass=0.
REQ-034 SHALL cover: gate_y stuck at 1 -> err_cnt=3, fail_vec=0, pass=0.
REQ-035 SHALL cover: start re-pulsed at cycles 5 and 13 with SETTLE=2 -> both ignored; exactly one done pulse, at cycle 13.
REQ-036 SHALL cover: rst asserted at cycle 6 -> IDLE next cycle, all outputs 0, no done pulse; a following start runs a full clean sweep.
REQ-037 SHALL cover: TRUTH=4'b1110 (OR) with an ideal OR model, SETTLE=1 -> done at cycle 9, pass=1.
